// File: rtl/systolic_result_drain_if.sv
// systolic_result_drain_if: valid/ready element stream leaving the result drain
interface systolic_result_drain_if #(parameter int OUT_W = 16);
  logic [OUT_W-1:0] m_data;
  logic m_valid;
  logic m_ready;
  logic m_last;
  logic [3:0] m_index;
  modport master(output m_data, m_valid, m_last, m_index, input m_ready);
  modport slave(input m_data, m_valid, m_last, m_index, output m_ready);
endinterface

// File: rtl/systolic_result_drain.sv
// systolic_result_drain: captures a 4x4 result matrix on a done rise and streams its 16 elements saturated to OUT_W
module systolic_result_drain #(parameter int OUT_W = 16) (
  input  logic clk,
  input  logic reset,
  input  logic [511:0] y_in,
  input  logic done_in,
  systolic_result_drain_if.master m,
  output logic busy,
  output logic sat_flag,
  output logic overrun
);
  localparam logic signed [32:0] MAXV = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
  localparam logic signed [32:0] MINV = -(33'sd1 <<< (OUT_W - 1));
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state;
  logic [0:15][31:0] mat;
  logic [0:15][31:0] y_v;
  logic [3:0] idx;
  logic done_d, rise, xfer, any_sat;
  function automatic logic [OUT_W-1:0] clamp(input logic [31:0] e);
    logic signed [32:0] v;
    v = {e[31], e};
    return v > MAXV ? MAXV[OUT_W-1:0] : v < MINV ? MINV[OUT_W-1:0] : e[OUT_W-1:0];
  endfunction
  function automatic logic ovf(input logic [31:0] e);
    logic signed [32:0] v;
    v = {e[31], e};
    return v > MAXV || v < MINV;
  endfunction
  assign y_v = y_in;
  assign rise = done_in & ~done_d;
  assign xfer = m.m_valid & m.m_ready;
  assign m.m_valid = state == STREAM;
  assign m.m_last = m.m_valid && idx == 4'd15;
  assign m.m_index = idx;
  assign m.m_data = clamp(mat[idx]);
  assign busy = m.m_valid;
  always_comb begin
    any_sat = 1'b0;
    for (int i = 0; i < 16; i++) any_sat = any_sat | ovf(y_v[i]);
  end
  // a last transfer frees the buffer on the same edge, so a coinciding rise is taken rather than dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      mat <= '0;
      done_d <= 1'b0;
      sat_flag <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done_d <= done_in;
      overrun <= state == STREAM && rise && !(xfer && m.m_last);
      if (rise && (state == IDLE || (xfer && m.m_last))) begin
        mat <= y_in;
        sat_flag <= any_sat;
        idx <= '0;
        state <= STREAM;
      end else if (xfer) begin
        idx <= idx + 4'd1;
        if (m.m_last) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_systolic_result_drain.sv
// tb_systolic_result_drain: random and directed stimulus against a queue-based model of the drain
module tb_systolic_result_drain;
  localparam int W = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [511:0] y_in = '0;
  logic done_in = 1'b0;
  logic busy, sat_flag, overrun;
  int n_chk = 0;
  int n_err = 0;
  longint q[$];
  bit m_sat, m_dd, m_ov;
  systolic_result_drain_if #(.OUT_W(W)) s();
  systolic_result_drain #(.OUT_W(W)) dut(.clk(clk), .reset(reset), .y_in(y_in), .done_in(done_in),
    .m(s.master), .busy(busy), .sat_flag(sat_flag), .overrun(overrun));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic longint sat(input longint v);
    longint hi, lo;
    hi = (longint'(1) << (W - 1)) - 1;
    lo = -hi - 1;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
  task automatic put(input int i, input longint v);
    y_in[511 - 32 * i -: 32] = 32'(v);
  endtask
  task automatic rand_y();
    longint v;
    for (int i = 0; i < 16; i++) begin
      v = ($urandom_range(0, 3) == 0) ? longint'($signed($urandom)) : longint'($urandom_range(0, 60000)) - 30000;
      put(i, v);
    end
  endtask
  task automatic compare();
    bit v;
    v = q.size() > 0;
    check("m_valid", 64'(s.m_valid), 64'(v));
    check("busy", 64'(busy), 64'(v));
    check("m_index", 64'(s.m_index), v ? 64'(16 - q.size()) : 64'd0);
    check("m_last", 64'(s.m_last), 64'(q.size() == 1));
    if (v) check("m_data", $signed(s.m_data), sat(q[0]));
    check("sat_flag", 64'(sat_flag), 64'(m_sat));
    check("overrun", 64'(overrun), 64'(m_ov));
  endtask
  task automatic model_edge();
    bit rise;
    longint v;
    rise = done_in && !m_dd;
    m_ov = 1'b0;
    if (q.size() > 0 && s.m_ready) void'(q.pop_front());
    if (rise) begin
      if (q.size() == 0) begin
        m_sat = 1'b0;
        for (int i = 0; i < 16; i++) begin
          v = longint'($signed(y_in[511 - 32 * i -: 32]));
          q.push_back(v);
          if (sat(v) != v) m_sat = 1'b1;
        end
      end else m_ov = 1'b1;
    end
    m_dd = done_in;
  endtask
  task automatic step(input bit d, input bit r);
    done_in = d;
    s.m_ready = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask
  task automatic do_reset(input bit d);
    done_in = d;
    #1 reset = 1'b1;
    #1;
    q.delete();
    m_sat = 1'b0;
    m_dd = 1'b0;
    m_ov = 1'b0;
    compare();
    check("m_data_rst", 64'(s.m_data), 64'd0);
    reset = 1'b0;
  endtask
  initial begin
    s.m_ready = 1'b0;
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) put(i, i + 1);
    step(1'b1, 1'b1);
    repeat (20) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    for (int i = 0; i < 16; i++) put(i, i * 100);
    put(3, 40000);
    put(7, -40000);
    step(1'b1, 1'b1);
    repeat (17) step(1'b0, 1'b1);
    rand_y();
    step(1'b1, 1'b1);
    for (int k = 0; k < 70; k++) step(1'b0, (k % 4 == 0) || (k % 4 == 3));
    rand_y();
    step(1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b1);
    rand_y();
    step(1'b1, 1'b1);
    repeat (15) step(1'b0, 1'b1);
    rand_y();
    step(1'b1, 1'b1);
    repeat (15) step(1'b0, 1'b1);
    rand_y();
    step(1'b1, 1'b1);
    repeat (17) step(1'b0, 1'b1);
    rand_y();
    step(1'b1, 1'b1);
    repeat (8) step(1'b0, 1'b1);
    do_reset(1'b0);
    repeat (5) step(1'b0, 1'b1);
    rand_y();
    do_reset(1'b1);
    step(1'b1, 1'b1);
    repeat (17) step(1'b0, 1'b1);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 9) == 0) rand_y();
      if ($urandom_range(0, 400) == 0) do_reset(1'($urandom_range(0, 1)));
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
    end
    repeat (20) step(1'b0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/systolic_result_drain.md
SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

Interface
REQ-001 The block SHALL have parameter OUT_W, default 16, giving the signed output element width; legal range 8..32.
REQ-002 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous, active-high reset.
REQ-004 The block SHALL have port y_in, input, 512 bits, sixteen signed 32-bit results; element (r,c) occupies bits [511-32*(4r+c) -: 32], r,c in 0..3.
REQ-005 The block SHALL have port done_in, input, 1 bit, result-ready level from the array; a rising edge marks a new matrix.
REQ-006 The block SHALL have port m_data, output, OUT_W bits, current saturated element.
REQ-007 The block SHALL have port m_valid, output, 1 bit, m_data is valid.
REQ-008 The block SHALL have port m_ready, input, 1 bit, downstream accepts m_data.
REQ-009 The block SHALL have port m_last, output, 1 bit, current element is index 15.
REQ-010 The block SHALL have port m_index, output, 4 bits, current element index 4r+c.
REQ-011 The block SHALL have port busy, output, 1 bit, a matrix is being drained.
REQ-012 The block SHALL have port sat_flag, output, 1 bit, at least one element of the held matrix saturated.
REQ-013 The block SHALL have port overrun, output, 1 bit, one-cycle pulse, a new matrix was dropped.

Function
REQ-014 The block SHALL register done_in into done_d each cycle; a rise is done_in=1 and done_d=0.
REQ-015 The FSM SHALL have states IDLE and STREAM.
REQ-016 In IDLE, a rise SHALL capture y_in into a 512-bit buffer, set m_index=0, and move to STREAM at the same edge.
REQ-017 m_valid SHALL be high exactly when in STREAM, so the first element is presented one cycle after the rise is sampled.
REQ-018 A transfer SHALL occur on any edge with m_valid=1 and m_ready=1; each transfer advances m_index by 1.
REQ-019 m_data, m_index and m_last SHALL stay stable while m_valid=1 and m_ready=0.
REQ-020 A transfer with m_last=1 SHALL return the FSM to IDLE with m_index=0, unless REQ-022 applies.
REQ-021 A rise in STREAM not coinciding with a last transfer SHALL be ignored; overrun SHALL pulse high for one cycle, and the buffer SHALL remain unchanged.
REQ-022 A rise coinciding with a last transfer SHALL capture the new matrix, stay in STREAM with m_index=0, and SHALL NOT pulse overrun.
REQ-023 m_data SHALL be element m_index saturated to signed OUT_W: values above 2^(OUT_W-1)-1 clamp to 2^(OUT_W-1)-1, values below -2^(OUT_W-1) clamp to -2^(OUT_W-1), all others pass unchanged.
REQ-024 With OUT_W=32, m_data SHALL equal the raw element.
REQ-025 sat_flag SHALL be computed over all 16 elements at capture, update at the capture edge, and hold until the next capture.
REQ-026 busy SHALL equal m_valid.
REQ-027 m_last SHALL be m_valid and (m_index==15).
REQ-028 A done_in level held high SHALL produce only one capture.

Reset
REQ-029 Asserting reset SHALL immediately set: state IDLE, m_valid=0, m_last=0, busy=0, m_index=0, sat_flag=0, overrun=0, done_d=0, buffer=0, m_data=0.
REQ-030 Reset asserted mid-stream SHALL abandon the matrix; no element SHALL be output after release without a new rise.
REQ-031 Because done_d resets to 0, done_in high at reset release SHALL count as a rise on the first clock edge.

Verification
REQ-032 Scenario: elements 0..15 equal 1..16, OUT_W=16, m_ready=1 -> m_data 1..16 on 16 consecutive cycles, starting one cycle after the rise; m_last only on 16; sat_flag=0.
REQ-033 Scenario: element 3 = 40000, element 7 = -40000, OUT_W=16 -> m_data 32767 at index 3 and -32768 at index 7; sat_flag=1 from the first element.
REQ-034 Scenario: m_ready toggling 1,0,0,1 -> m_data and m_index frozen during the 0 cycles; exactly 16 transfers with no loss or duplicates.
REQ-035 Scenario: second rise at index 5 -> overrun is one one-cycle pulse; the remaining elements come from the first matrix.
REQ-036 Scenario: second rise on the index-15 transfer edge -> index 0 of the second matrix appears on the next cycle, m_valid stays continuously high, overrun=0.
REQ-037 Scenario: reset pulse at index 8 with done_in low -> all outputs return to reset values; m_valid stays 0 until the next rise.
